// File: rtl/dendy_pkg.sv
// Shared definitions for the Dendy CPU-side peripherals: the sprite DMA
// trigger address and the sprite DMA state encoding.
package dendy_pkg;

    // CPU address whose write starts a sprite DMA transfer.
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    // Sprite DMA sequencing states.
    //   IDLE  : waiting for a write to the DMA register
    //   DUMMY : first stalled CPU cycle after the trigger
    //   ALIGN : extra cycle when the transfer started on an odd CPU cycle
    //   READ  : source byte addressed on the PRG/RAM port
    //   WRITE : captured byte written into OAM
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DUMMY = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine. A CPU write to the DMA register stalls the CPU and
// copies the 256 bytes of page {value,00..FF} into OAM, starting at the
// current OAMADDR and wrapping modulo 256. Each byte takes one READ CPU
// cycle and one WRITE CPU cycle; a dummy cycle (plus an alignment cycle
// when the trigger lands on an odd CPU cycle) precedes the copy.
//
// Handshake: ce_cpu is a one-clock25 strobe marking the end of a CPU cycle.
// All sequencing decisions happen on clock25 edges where ce_cpu is high.
// The read port has no ready: mem_a is held stable for the whole READ
// cycle and mem_i is sampled on the closing ce_cpu edge, so ce_cpu must be
// at least two clock25 periods apart for the one-clock read latency.
module oam_dma
    import dendy_pkg::*;
#(
    parameter logic [15:0] DMA_REG   = DMA_REG_ADDR,
    parameter bit          ODD_ALIGN = 1'b1
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_w,
    input  logic [7:0]  oam_addr,
    output logic        cpu_stall,
    output logic [15:0] mem_a,
    input  logic [7:0]  mem_i,
    output logic        mem_r,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_w,
    output logic        busy
);

    dma_state_t  state;
    dma_state_t  state_nx;

    logic        parity;      // parity of the CPU cycle currently running
    logic        odd_trig;    // trigger landed on an odd CPU cycle
    logic [7:0]  page;        // source page latched at trigger
    logic [7:0]  base;        // OAM start index latched at trigger
    logic [7:0]  idx;         // byte counter within the page
    logic [7:0]  data_q;      // byte read from PRG/RAM, awaiting its OAM write
    logic [15:0] mem_a_hold;  // last read address, presented while not reading
    logic        trigger;

    // A trigger is only honoured from IDLE; writes during a transfer are dropped.
    assign trigger = ce_cpu & cpu_w & (cpu_a == DMA_REG) & (state == IDLE);

    // CPU-cycle parity, toggling on every CPU cycle including stalled ones.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (ce_cpu) begin
            parity <= ~parity;
        end
    end

    // State register.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; every transition except the trigger waits for ce_cpu.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx = DUMMY;
                end
            end
            DUMMY: begin
                if (ce_cpu) begin
                    // The alignment decision uses the parity of the trigger
                    // cycle, captured when the transfer was started.
                    if (ODD_ALIGN && odd_trig) begin
                        state_nx = ALIGN;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            ALIGN: begin
                if (ce_cpu) begin
                    state_nx = READ;
                end
            end
            READ: begin
                if (ce_cpu) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (ce_cpu) begin
                    if (idx == 8'hFF) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Transfer context: page/base/trigger parity latched on the trigger.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            page     <= 8'h00;
            base     <= 8'h00;
            odd_trig <= 1'b0;
        end else if (trigger) begin
            page     <= cpu_o;
            base     <= oam_addr;
            odd_trig <= parity;
        end
    end

    // Byte counter: cleared on trigger, stepped after each OAM write (wraps at 256).
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            idx <= 8'h00;
        end else if (trigger) begin
            idx <= 8'h00;
        end else if ((state == WRITE) && ce_cpu) begin
            idx <= idx + 8'h01;
        end
    end

    // Data latch: capture the read byte at the edge that closes the READ cycle.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            data_q <= 8'h00;
        end else if ((state == READ) && ce_cpu) begin
            data_q <= mem_i;
        end
    end

    // Remember the read address so mem_a keeps its last value outside READ.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            mem_a_hold <= 16'h0000;
        end else if (state == READ) begin
            mem_a_hold <= {page, idx};
        end
    end

    // Output decode. The source address stays inside the latched page because
    // only the low byte comes from the wrapping counter.
    always_comb begin
        busy      = (state != IDLE);
        cpu_stall = (state != IDLE);
        mem_r     = (state == READ);
        mem_a     = (state == READ) ? {page, idx} : mem_a_hold;
        oam_w     = (state == WRITE) & ce_cpu;
        oam_a     = base + idx;
        oam_d     = data_q;
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for the sprite DMA engine: a table of transfers (page, OAM base,
// trigger parity) with expected stall lengths, plus directed sequences for
// retrigger, reset mid-transfer and non-trigger accesses.
module tb_oam_dma;

    localparam logic [15:0] DMA_ADDR = 16'h4014;

    // ---------------- clock / reset ----------------
    logic        clock25 = 1'b0;
    logic        reset   = 1'b1;
    logic        ce_cpu  = 1'b0;
    int          ce_div  = 0;

    always #5 clock25 = ~clock25;

    // CPU strobe: one clock25 in three, changing just after the rising edge.
    always @(posedge clock25) begin
        #1;
        ce_div = (ce_div == 2) ? 0 : ce_div + 1;
        ce_cpu = (ce_div == 0);
    end

    // Reference parity: parity of the running CPU cycle, 0 after reset.
    logic tb_par = 1'b0;
    always @(posedge clock25 or posedge reset) begin
        if (reset) tb_par <= 1'b0;
        else if (ce_cpu) tb_par <= ~tb_par;
    end

    // ---------------- DUT signals ----------------
    logic [15:0] cpu_a    = 16'h0000;
    logic [7:0]  cpu_o    = 8'h00;
    logic        cpu_w    = 1'b0;
    logic [7:0]  oam_addr = 8'h00;
    logic [7:0]  mem_i    = 8'h00;
    logic [7:0]  mem_i_na = 8'h00;

    logic        cpu_stall, mem_r, oam_w, busy;
    logic [15:0] mem_a;
    logic [7:0]  oam_a, oam_d;

    logic        cpu_stall_na, mem_r_na, oam_w_na, busy_na;
    logic [15:0] mem_a_na;
    logic [7:0]  oam_a_na, oam_d_na;

    oam_dma dut (
        .clock25   (clock25),
        .reset     (reset),
        .ce_cpu    (ce_cpu),
        .cpu_a     (cpu_a),
        .cpu_o     (cpu_o),
        .cpu_w     (cpu_w),
        .oam_addr  (oam_addr),
        .cpu_stall (cpu_stall),
        .mem_a     (mem_a),
        .mem_i     (mem_i),
        .mem_r     (mem_r),
        .oam_a     (oam_a),
        .oam_d     (oam_d),
        .oam_w     (oam_w),
        .busy      (busy)
    );

    oam_dma #(.ODD_ALIGN(1'b0)) dut_na (
        .clock25   (clock25),
        .reset     (reset),
        .ce_cpu    (ce_cpu),
        .cpu_a     (cpu_a),
        .cpu_o     (cpu_o),
        .cpu_w     (cpu_w),
        .oam_addr  (oam_addr),
        .cpu_stall (cpu_stall_na),
        .mem_a     (mem_a_na),
        .mem_i     (mem_i_na),
        .mem_r     (mem_r_na),
        .oam_a     (oam_a_na),
        .oam_d     (oam_d_na),
        .oam_w     (oam_w_na),
        .busy      (busy_na)
    );

    // ---------------- memory model ----------------
    logic [7:0] ram [0:65535];

    // One-clock read latency.
    always @(posedge clock25) begin
        mem_i    <= ram[mem_a];
        mem_i_na <= ram[mem_a_na];
    end

    // ---------------- scoreboard ----------------
    int          n_tests     = 0;
    int          n_fail      = 0;
    int          oam_w_cnt   = 0;
    int          na_stall_ce = 0;
    logic [15:0] exp_q[$];   // {oam_a, oam_d} in expected write order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock25) begin
        if (!reset && oam_w === 1'b1) begin
            oam_w_cnt++;
            if (exp_q.size() == 0) begin
                check("oam_w_unexpected", {16'h0, oam_a, oam_d}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("oam_write", {16'h0, oam_a, oam_d}, {16'h0, e});
            end
        end
        if (ce_cpu && cpu_stall_na === 1'b1) na_stall_ce++;
    end

    // ---------------- driver tasks ----------------
    // Write the DMA register on a CPU cycle of the requested parity.
    task automatic trigger(input logic [7:0] page, input logic want_odd);
        int k;
        @(negedge clock25);
        k = 0;
        while (!(ce_cpu && tb_par == want_odd) && k < 20) begin
            @(negedge clock25);
            k++;
        end
        check("trigger_slot_found", (k < 20) ? 32'd1 : 32'd0, 32'd1);
        cpu_a = DMA_ADDR;
        cpu_o = page;
        cpu_w = 1'b1;
        @(negedge clock25);
        cpu_w = 1'b0;
        cpu_a = 16'h0000;
    endtask

    // One bus access; with_ce selects a cycle with or without ce_cpu.
    task automatic poke(input logic [15:0] addr, input logic wr, input logic with_ce);
        @(negedge clock25);
        while (ce_cpu !== with_ce) @(negedge clock25);
        cpu_a = addr;
        cpu_o = 8'h07;
        cpu_w = wr;
        @(negedge clock25);
        cpu_w = 1'b0;
        cpu_a = 16'h0000;
    endtask

    // Observe a transfer until stall falls; counts nothing past 4000 clocks.
    typedef struct {
        logic [7:0] page;
        logic [7:0] base;
        logic       odd;
        logic       retrig;
        int         exp_stall;
        int         exp_first;
        int         exp_na;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int   stall_ce, first, page_bad, busy_bad;
        logic done, rt;
        oam_addr = v.base;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ii, oa;
            ii = i[7:0];
            oa = v.base + ii;
            exp_q.push_back({oa, ram[{v.page, ii}]});
        end
        na_stall_ce = 0;
        trigger(v.page, v.odd);
        stall_ce = 0; first = -1; page_bad = 0; busy_bad = 0; done = 1'b0; rt = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (busy !== cpu_stall) busy_bad++;
            if (cpu_stall !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (mem_r === 1'b1) begin
                if (first < 0) begin
                    first = stall_ce;
                    check({tag, "_first_mem_a"}, {16'h0, mem_a}, {16'h0, v.page, 8'h00});
                end
                if (mem_a[15:8] !== v.page) page_bad++;
            end
            if (v.retrig && !rt && ce_cpu && stall_ce >= 100) begin
                cpu_a = DMA_ADDR;
                cpu_o = 8'h05;
                cpu_w = 1'b1;
                rt = 1'b1;
            end else begin
                cpu_w = 1'b0;
                cpu_a = 16'h0000;
            end
            if (ce_cpu) stall_ce++;
            @(negedge clock25);
        end
        cpu_w = 1'b0;
        check({tag, "_released"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_ce"}, stall_ce, v.exp_stall);
        check({tag, "_first_read_ce"}, first, v.exp_first);
        check({tag, "_page_bad"}, page_bad, 0);
        check({tag, "_busy_vs_stall"}, busy_bad, 0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_mem_a_hold"}, {16'h0, mem_a}, {16'h0, v.page, 8'hFF});
        check({tag, "_mem_r_idle"}, {31'd0, mem_r}, 32'd0);
        check({tag, "_na_stall_ce"}, na_stall_ce, v.exp_na);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[5];
    int   saved;
    int   seen;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] ad;
            ad = a[15:0];
            ram[a] = ad[7:0] ^ 8'hA5 ^ (ad[15:8] - 8'h02);
        end

        //          page   base   odd   retrig stall first na
        vecs[0] = '{8'h02, 8'h00, 1'b0, 1'b0, 513, 1, 513};
        vecs[1] = '{8'h02, 8'h00, 1'b1, 1'b0, 514, 2, 513};
        vecs[2] = '{8'h03, 8'hF0, 1'b0, 1'b0, 513, 1, 513};
        vecs[3] = '{8'h02, 8'h00, 1'b0, 1'b1, 513, 1, 513};
        vecs[4] = '{8'h41, 8'h07, 1'b1, 1'b0, 514, 2, 513};

        // Reset state
        repeat (3) @(posedge clock25);
        #2;
        check("rst_cpu_stall", {31'd0, cpu_stall}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_mem_r", {31'd0, mem_r}, 0);
        check("rst_oam_w", {31'd0, oam_w}, 0);
        check("rst_mem_a", {16'd0, mem_a}, 0);
        check("rst_oam_a", {24'd0, oam_a}, 0);
        check("rst_oam_d", {24'd0, oam_d}, 0);
        @(negedge clock25);
        reset = 1'b0;
        repeat (4) @(negedge clock25);

        // Table of transfers
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (5) @(negedge clock25);
        end

        // Reset in the middle of a transfer
        oam_addr = 8'h00;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ii;
            ii = i[7:0];
            exp_q.push_back({ii, ram[{8'h02, ii}]});
        end
        oam_w_cnt = 0;
        trigger(8'h02, 1'b0);
        for (int k = 0; k < 3000 && oam_w_cnt < 100; k++) @(negedge clock25);
        check("midrst_reached_100", oam_w_cnt, 100);
        @(posedge clock25);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_cpu_stall", {31'd0, cpu_stall}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_mem_r", {31'd0, mem_r}, 0);
        check("midrst_oam_w", {31'd0, oam_w}, 0);
        check("midrst_mem_a", {16'd0, mem_a}, 0);
        check("midrst_oam_a", {24'd0, oam_a}, 0);
        check("midrst_oam_d", {24'd0, oam_d}, 0);
        exp_q.delete();
        repeat (3) @(negedge clock25);
        reset = 1'b0;
        saved = oam_w_cnt;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock25);
            if (cpu_stall !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("postrst_no_writes", oam_w_cnt, saved);
        check("postrst_idle", seen, 0);
        run_vec(vecs[0], "postrst");
        repeat (5) @(negedge clock25);

        // Accesses that must not start a transfer
        begin
            logic [15:0] addrs[4];
            logic        wrs[4];
            logic        ces[4];
            addrs[0] = 16'h4013; wrs[0] = 1'b1; ces[0] = 1'b1;
            addrs[1] = 16'h4015; wrs[1] = 1'b1; ces[1] = 1'b1;
            addrs[2] = 16'h4014; wrs[2] = 1'b0; ces[2] = 1'b1;
            addrs[3] = 16'h4014; wrs[3] = 1'b1; ces[3] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                poke(addrs[i], wrs[i], ces[i]);
                seen = 0;
                for (int k = 0; k < 30; k++) begin
                    if (cpu_stall !== 1'b0 || busy !== 1'b0 || cpu_stall_na !== 1'b0) seen++;
                    @(negedge clock25);
                end
                check($sformatf("nontrig%0d", i), seen, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
